// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the set/reset command front-end.
//   state_t : FSM encoding (IDLE, SET_P, CLR_P, GAP), 2 bits
//   CNT_W   : width of the debounce and gap counters (covers 1..255 / 0..255)
package sr_cmd_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    CLR_P = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/sr_debounce.sv
// One request channel: 2-FF synchroniser, debounce counter, rising-edge detect.
//   clk  : clock
//   rst  : synchronous reset, active low
//   req  : raw asynchronous request, active high
//   rise : one-cycle pulse when the debounced level goes 0 -> 1
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic rise
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic             deb_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= req;
      sync2 <= sync1;
      deb_d <= deb;
      // Any cycle where the synchronised level agrees with deb restarts the count.
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = deb & ~deb_d;

endmodule

// File: rtl/sr_cmd_gen.sv
// Command front-end for the set/reset flip-flop stage. Debounced rising edges
// of set_req/clr_req become single-cycle s/r pulses, never both at once;
// simultaneous pending requests are dropped and flagged.
//   clk      : clock
//   rst      : synchronous reset, active low
//   set_req  : raw set request
//   clr_req  : raw clear request
//   s, r     : one-cycle pulses to the flip-flop, decoded from the state register
//   busy     : FSM not in IDLE
//   conflict : one-cycle pulse when both requests were pending in IDLE
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  logic             set_rise;
  logic             clr_rise;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] gap_cnt_n;
  logic             set_pend;
  logic             set_pend_n;
  logic             clr_pend;
  logic             clr_pend_n;
  logic             conflict_n;

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
    .clk  (clk),
    .rst  (rst),
    .req  (set_req),
    .rise (set_rise)
  );

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
    .clk  (clk),
    .rst  (rst),
    .req  (clr_req),
    .rise (clr_rise)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      set_pend <= 1'b0;
      clr_pend <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_n;
      gap_cnt  <= gap_cnt_n;
      set_pend <= set_pend_n;
      clr_pend <= clr_pend_n;
      conflict <= conflict_n;
    end
  end

  always_comb begin
    state_n    = state;
    gap_cnt_n  = gap_cnt;
    set_pend_n = set_pend | set_rise;
    clr_pend_n = clr_pend | clr_rise;
    conflict_n = 1'b0;
    unique case (state)
      IDLE: begin
        // A rise landing on the serving cycle is kept as a fresh command.
        if (set_pend && clr_pend) begin
          set_pend_n = set_rise;
          clr_pend_n = clr_rise;
          conflict_n = 1'b1;
        end else if (set_pend) begin
          set_pend_n = set_rise;
          state_n    = SET_P;
        end else if (clr_pend) begin
          clr_pend_n = clr_rise;
          state_n    = CLR_P;
        end
      end
      SET_P, CLR_P: begin
        gap_cnt_n = '0;
        state_n   = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_n = '0;
          state_n   = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign s    = (state == SET_P);
  assign r    = (state == CLR_P);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen with default parameters (DB_CYCLES=4, GAP_CYCLES=2).
// Cycle index i counts edges inside a watch window; edge i samples the inputs
// driven just before it, and outputs are checked 1 time unit after edge i.
// A request first sampled at edge i=1 gives s/r high after edge 8.
module tb_sr_cmd_gen;

  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst;
  logic set_req;
  logic clr_req;
  logic s;
  logic r;
  logic busy;
  logic conflict;

  int checks   = 0;
  int failures = 0;

  sr_cmd_gen #(.DB_CYCLES(4), .GAP_CYCLES(2)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .set_req  (set_req),
    .clr_req  (clr_req),
    .s        (s),
    .r        (r),
    .busy     (busy),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int i, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s i=%0d observed=%0b expected=%0b", tag, i, obs, exp);
    end
  endtask

  // set_req high for edges in [son,soff), clr_req for [con,coff); expected
  // pulses at s_at / r_at / c_at (0 = none); busy covers each pulse plus GAP.
  task automatic watch(input string tag, input int n,
                       input int son, input int soff, input int con, input int coff,
                       input int s_at, input int r_at, input int c_at,
                       input bit chk_deb);
    logic busy_e;
    for (int i = 1; i <= n; i++) begin
      set_req = (i >= son) && (i < soff);
      clr_req = (i >= con) && (i < coff);
      @(posedge clk);
      #1;
      busy_e = ((s_at != 0) && (i >= s_at) && (i <= s_at + GAP)) ||
               ((r_at != 0) && (i >= r_at) && (i <= r_at + GAP));
      chk({tag, ".s"},        i, s,        (i == s_at));
      chk({tag, ".r"},        i, r,        (i == r_at));
      chk({tag, ".conflict"}, i, conflict, (i == c_at));
      chk({tag, ".busy"},     i, busy,     busy_e);
      if (chk_deb) chk({tag, ".deb"}, i, u_dut.u_set_db.deb, 1'b0);
    end
  endtask

  initial begin
    rst     = 1'b0;
    set_req = 1'b1;
    clr_req = 1'b0;

    // Reset held 3 cycles with set_req high: everything stays quiet.
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst.s",        i, s,        1'b0);
      chk("rst.r",        i, r,        1'b0);
      chk("rst.busy",     i, busy,     1'b0);
      chk("rst.conflict", i, conflict, 1'b0);
    end
    rst = 1'b1;

    // After release the still-high set_req needs a full debounce: s after edge 8.
    watch("post_release", 22, 1, 12, 0, 0, 8, 0, 0, 1'b0);

    // Long held set request: one s pulse only, r stays low.
    watch("held", 24, 1, 16, 0, 0, 8, 0, 0, 1'b0);

    // 3-cycle glitch: deb never rises, no pulse.
    watch("glitch3", 16, 1, 4, 0, 0, 0, 0, 0, 1'b1);

    // 4-cycle pulse: just qualifies.
    watch("pulse4", 18, 1, 5, 0, 0, 8, 0, 0, 1'b0);

    // Both requests rise together: conflict after edge 8, no s/r, never busy.
    watch("conflict", 24, 1, 12, 1, 12, 0, 0, 8, 1'b0);

    // Set served, clear qualifies during GAP: r exactly 4 edges after s.
    watch("set_then_clr", 26, 1, 14, 3, 14, 8, 12, 0, 1'b0);

    // Reset during GAP with a clear pending: the clear is discarded.
    watch("rstgap", 9, 1, 40, 3, 40, 8, 0, 0, 1'b0);
    chk("rstgap.clr_pend_pre", 9, u_dut.clr_pend, 1'b1);
    rst     = 1'b0;
    set_req = 1'b0;
    clr_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rstgap.busy",     10, busy,           1'b0);
    chk("rstgap.s",        10, s,              1'b0);
    chk("rstgap.r",        10, r,              1'b0);
    chk("rstgap.conflict", 10, conflict,       1'b0);
    chk("rstgap.clr_pend", 10, u_dut.clr_pend, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    watch("post_rstgap", 20, 0, 0, 0, 0, 0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
